// File: rtl/lerp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lerp_pipe
//  Description : Three-stage pipelined fixed-point linear interpolator /
//                extrapolator. Computes p0 + round_half_up((p1-p0)*t) with
//                t in unsigned Q1.FRAC_W, saturated to the unsigned pixel
//                range. Valid/ready on both sides, single global advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module lerp_pipe #(
    parameter int PX_W   = 8,
    parameter int FRAC_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PX_W-1:0]   p0,
    input  logic [PX_W-1:0]   p1,
    input  logic [FRAC_W:0]   frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PX_W-1:0]   px_out,
    output logic              sat
);

    localparam int DIFF_W = PX_W + 1;
    localparam int FEXT_W = FRAC_W + 2;
    localparam int PROD_W = DIFF_W + FEXT_W;
    localparam int SUM_W  = PX_W + 3;
    localparam logic [PROD_W-1:0] RND = PROD_W'(1) << (FRAC_W - 1);

    // Stage registers
    logic                     v1_q, v2_q, v3_q;
    logic [PX_W-1:0]          p0_s1_q, p0_s2_q;
    logic signed [DIFF_W-1:0] diff_q;
    logic [FRAC_W:0]          frac_q;
    logic signed [PROD_W-1:0] prod_q;
    logic [PX_W-1:0]          px_q;
    logic                     sat_q;

    // Combinational next-state values
    logic                     w_adv;
    logic signed [DIFF_W-1:0] diff_d;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] w_rnd;
    logic signed [SUM_W-1:0]  w_shr;
    logic signed [SUM_W-1:0]  w_sum;
    logic [PX_W-1:0]          px_d;
    logic                     sat_d;

    // The whole pipe moves as one: it may shift whenever the output slot is
    // empty or is being drained this cycle.
    assign w_adv     = ~v3_q | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = v3_q;
    assign px_out    = px_q;
    assign sat       = sat_q;

    // S1/S2/S3 arithmetic: difference, full-width product, round/shift/add/clamp
    always_comb begin
        diff_d = $signed({1'b0, p1}) - $signed({1'b0, p0});
        prod_d = PROD_W'(diff_q) * PROD_W'($signed({1'b0, frac_q}));
        w_rnd  = prod_q + $signed(RND);
        // Dropping the low FRAC_W bits of a signed value is an arithmetic shift.
        w_shr  = w_rnd[PROD_W-1:FRAC_W];
        w_sum  = $signed({{(SUM_W-PX_W){1'b0}}, p0_s2_q}) + w_shr;
        px_d   = w_sum[PX_W-1:0];
        sat_d  = 1'b0;
        if (w_sum[SUM_W-1]) begin
            px_d  = '0;
            sat_d = 1'b1;
        end else if (|w_sum[SUM_W-2:PX_W]) begin
            px_d  = '1;
            sat_d = 1'b1;
        end
    end

    // Valid bits shift on advance; reset flushes everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (w_adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Data registers load only behind a valid bit so idle inputs never propagate
    always_ff @(posedge clk) begin
        if (w_adv && in_valid) begin
            p0_s1_q <= p0;
            diff_q  <= diff_d;
            frac_q  <= frac;
        end
        if (w_adv && v1_q) begin
            p0_s2_q <= p0_s1_q;
            prod_q  <= prod_d;
        end
    end

    // Output register: cleared on reset, held across stalls and bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            px_q  <= '0;
            sat_q <= 1'b0;
        end else if (w_adv && v2_q) begin
            px_q  <= px_d;
            sat_q <= sat_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/lerp_pipe.md
Name: lerp_pipe

Overview:
- Pipelined fixed-point 1D linear interpolator / extrapolator for pixel streams.
- Sits directly upstream of the bilinear/remap datapath: consumes two neighbour pixels plus a fractional weight, emits one interpolated, rounded, saturated pixel per cycle.
- Building block for line interpolation; two instances plus a third form the bilinear stage.
- Valid/ready handshake on both sides with full backpressure.

Parameters:
- PX_W, 8, pixel width; unsigned integer.
- FRAC_W, 7, fractional bits of weight; weight format unsigned Q1.FRAC_W, range [0, 2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts the sample this cycle.
- p0  in  PX_W  left pixel, unsigned.
- p1  in  PX_W  right pixel, unsigned.
- frac  in  FRAC_W+1  weight t, unsigned Q1.FRAC_W (1.0 = 2^FRAC_W).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- px_out  out  PX_W  interpolated pixel, unsigned.
- sat  out  1  px_out was clamped (underflow or overflow).

Behaviour:
- Function: px_out = clamp(p0 + floor(((p1 - p0) * t * 2^FRAC_W + 2^(FRAC_W-1)) / 2^FRAC_W), 0, 2^PX_W - 1), i.e. round-half-up.
- Stage 1 (S1): register p0 and diff = $signed({1'b0,p1}) - $signed({1'b0,p0}) (PX_W+1 bits signed); register frac.
- Stage 2 (S2): prod = diff * $signed({1'b0,frac}); signed, width (PX_W+1)+(FRAC_W+2). No truncation.
- Stage 3 (S3): add rounding constant 2^(FRAC_W-1), arithmetic shift right by FRAC_W, sign-extend p0 and add. Sum width PX_W+3 signed. If sum < 0, px_out = 0 and sat = 1. If sum > 2^PX_W - 1, px_out = all ones and sat = 1. Otherwise px_out = sum[PX_W-1:0] and sat = 0.
- Each stage has a valid bit. Global advance enable: adv = ~out_valid | out_ready. in_ready = adv (combinational).
- Transfer rules: an input transfers on in_valid & in_ready. An output transfers on out_valid & out_ready. When adv = 1, all stages shift by one and bubbles propagate as valid = 0. When adv = 0, all stage registers hold.
- Latency: exactly 3 clk from input transfer to out_valid, when out_ready is held high. Throughput is 1 sample/clk.
- Ordering: results leave in acceptance order. No drops and no duplicates under any out_ready pattern.
- px_out and sat hold stable while out_valid = 1 and out_ready = 0.
- Reset: when rst_n = 0 at a clock edge, all valid bits clear, and px_out = 0, sat = 0, out_valid = 0. in_ready reads 1 on the cycle after reset. Reset mid-stream discards all in-flight samples; no partial output.
- Boundaries:
  - frac = 0 gives p0 exactly.
  - frac = 2^FRAC_W gives p1 exactly.
  - p0 = p1 gives p0 for any frac.
  - frac > 1.0 extrapolates and may saturate.
  - Data inputs are ignored when in_valid = 0. X on p0/p1/frac must not reach outputs while the corresponding valid is 0.

Test Plan:
- Interpolation (PX_W=8, FRAC_W=7): p0=10, p1=20, frac=64 -> px_out=15, sat=0, out_valid exactly 3 clk after acceptance. p0=200, p1=100, frac=32 -> 175, sat=0.
- Endpoints: p0=37, p1=211 with frac=0 -> 37; frac=128 -> 211. p0=p1=90, frac=255 -> 90. All with sat=0.
- Saturation: p0=100, p1=250, frac=255 -> px_out=255, sat=1. p0=200, p1=10, frac=200 -> px_out=0, sat=1.
- Rounding: p0=0, p1=1, frac=64 -> 1 (half rounds up). p0=1, p1=0, frac=64 -> 1 (−0.5 rounds up to 0 offset). frac=63 -> 0 and 1 respectively.
- Backpressure: stream 6 back-to-back samples, drop out_ready low for 5 clk after the first output, then raise it. in_ready falls the same cycle out_ready falls while out_valid=1. All 6 results emerge in order, with no loss or duplication, and px_out is stable during the stall. Also run random in_valid/out_ready over 10k samples against a reference model.
- Reset mid-stream: 3 samples in flight, pulse rst_n low 1 clk. Next cycle out_valid=0, px_out=0, sat=0, in_ready=1. A new sample p0=4, p1=8, frac=64 -> 6 appears 3 clk after acceptance, and nothing from before reset appears.
